// File: rtl/zepto_ctrl.sv
// zepto_ctrl: multi-cycle sequencer for the 16-bit ALU.
// It fetches an instruction, reads two registers, issues operands to the ALU,
// then either writes the result back or redirects the pc.
module zepto_ctrl #(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [15:0] rf_rdata_a,
    input  logic [15:0] rf_rdata_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] alu_imm,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_res,
    input  logic        alu_zero,
    input  logic [3:0]  alu_status,
    output logic [15:0] pc,
    output logic        halted,
    output logic        illegal,
    output logic        zero_flag,
    output logic [15:0] instr_count
);

    localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALTED, S_ERROR
    } state_t;

    state_t          r_state, w_state_next;
    logic [15:0]     r_inst;
    logic [TW-1:0]   r_timer;
    logic [15:0]     r_pc;
    logic [15:0]     r_count;
    logic [15:0]     r_alu_a, r_alu_b, r_alu_imm, r_wdata;
    logic [3:0]      r_alu_op;
    logic            r_zero_cap, r_zero_flag;

    // Instruction field decode from the latched instruction word.
    logic [3:0] w_opc, w_rd;
    logic       w_is_reg_alu, w_is_imm_alu, w_is_alu, w_is_skip, w_is_jump, w_is_halt;
    logic       w_is_illegal, w_timeout, w_skip_take;

    assign w_opc        = r_inst[15:12];
    assign w_rd         = r_inst[11:8];
    assign w_is_reg_alu = (w_opc <= 4'h4);
    assign w_is_imm_alu = (w_opc >= 4'h8) && (w_opc <= 4'hC);
    assign w_is_alu     = w_is_reg_alu || w_is_imm_alu;
    assign w_is_skip    = (w_opc == 4'hD);
    assign w_is_jump    = (w_opc == 4'hE);
    assign w_is_halt    = (w_opc == 4'hF);
    assign w_is_illegal = ((w_opc >= 4'h5) && (w_opc <= 4'h7)) ||
                          (w_is_skip && (w_rd[3:2] != 2'b00));
    assign w_timeout    = (r_timer == TW'(FETCH_TIMEOUT - 1));

    // alu_status is {eq, neq, geq, lt}; cond 00 selects eq (bit 3) down to 11 -> lt (bit 0).
    always_comb begin
        w_skip_take = 1'b0;
        case (w_rd[1:0])
            2'b00:   w_skip_take = alu_status[3];
            2'b01:   w_skip_take = alu_status[2];
            2'b10:   w_skip_take = alu_status[1];
            default: w_skip_take = alu_status[0];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; HALTED and ERROR are only left through reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_next = S_FETCH;
            S_FETCH: begin
                if (imem_valid)     w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_DECODE: begin
                if (w_is_illegal)   w_state_next = S_ERROR;
                else if (w_is_halt) w_state_next = S_HALTED;
                else                w_state_next = S_EXECUTE;
            end
            S_EXECUTE:   w_state_next = w_is_alu ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK: w_state_next = S_FETCH;
            S_HALTED:    w_state_next = S_HALTED;
            S_ERROR:     w_state_next = S_ERROR;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Datapath: fetch latch, operand issue, result capture, pc and retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst      <= 16'h0000;
            r_timer     <= '0;
            r_pc        <= RESET_PC;
            r_count     <= 16'h0000;
            r_alu_a     <= 16'h0000;
            r_alu_b     <= 16'h0000;
            r_alu_imm   <= 16'h0000;
            r_alu_op    <= 4'h0;
            r_wdata     <= 16'h0000;
            r_zero_cap  <= 1'b0;
            r_zero_flag <= 1'b0;
        end else begin
            r_timer <= '0;
            case (r_state)
                S_FETCH: begin
                    if (imem_valid)      r_inst  <= imem_data;
                    else if (!w_timeout) r_timer <= r_timer + 1'b1;
                end
                S_DECODE: begin
                    if (!w_is_illegal && (w_is_alu || w_is_skip)) begin
                        r_alu_a  <= rf_rdata_a;
                        r_alu_op <= w_is_skip ? 4'h0 : {1'b0, w_opc[2:0]};
                        if (w_is_imm_alu) begin
                            r_alu_b   <= (w_opc == 4'hA) ? 16'hFFFF : 16'h0000;
                            r_alu_imm <= {12'h000, r_inst[3:0]};
                        end else begin
                            r_alu_b   <= rf_rdata_b;
                            r_alu_imm <= (w_opc == 4'h2) ? 16'hFFFF : 16'h0000;
                        end
                    end
                    if (!w_is_illegal && w_is_halt) r_count <= r_count + 16'd1;
                end
                S_EXECUTE: begin
                    if (w_is_alu) begin
                        r_wdata    <= alu_res;
                        r_zero_cap <= alu_zero;
                    end else begin
                        if (w_is_skip)      r_pc <= r_pc + (w_skip_take ? 16'd2 : 16'd1);
                        else if (w_is_jump) r_pc <= {r_pc[15:8], r_inst[7:0]};
                        r_count <= r_count + 16'd1;
                    end
                end
                S_WRITEBACK: begin
                    r_zero_flag <= r_zero_cap;
                    r_pc        <= r_pc + 16'd1;
                    r_count     <= r_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign rf_raddr_a  = r_inst[7:4];
    assign rf_raddr_b  = r_inst[3:0];
    assign rf_we       = (r_state == S_WRITEBACK);
    assign rf_waddr    = r_inst[11:8];
    assign rf_wdata    = r_wdata;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_imm     = r_alu_imm;
    assign alu_op      = r_alu_op;
    assign pc          = r_pc;
    assign halted      = (r_state == S_HALTED);
    assign illegal     = (r_state == S_ERROR);
    assign zero_flag   = r_zero_flag;
    assign instr_count = r_count;

endmodule
